// File: rtl/ctrl_pkg.sv
// Shared encodings and the ID/EX control bundle for the RV32IM decode/control stage.
package ctrl_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_B = 3'd1,
    IMM_S = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_src_e;

  typedef enum logic [1:0] {
    OPA_RS1  = 2'd0,
    OPA_PC   = 2'd1,
    OPA_ZERO = 2'd2
  } op_a_sel_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_WAIT = 2'd2
  } md_state_e;

  typedef struct packed {
    logic       reg_write;
    logic [3:0] alu_ctrl;
    logic       alu_src;
    imm_src_e   imm_src;
    op_a_sel_e  op_a_sel;
    logic       dest_src;
    logic [2:0] mem_ctrl;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       md_sel;
    logic [2:0] md_op;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

  // Bundle that writes back the M-unit result for the given funct3.
  function automatic ctrl_bundle_t md_bundle(input logic [2:0] funct3);
    ctrl_bundle_t b;
    b           = CTRL_BUBBLE;
    b.reg_write = 1'b1;
    b.md_sel    = 1'b1;
    b.md_op     = funct3;
    return b;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Pure combinational RV32IM decoder: opcode/funct fields to control bundle plus
// M-op and illegal-instruction flags.
module decode_comb
  import ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic [6:0]   funct7,
  output ctrl_bundle_t ctrl,
  output logic         is_m,
  output logic         illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    ctrl    = CTRL_BUBBLE;
    is_m    = 1'b0;
    illegal = 1'b0;

    unique case (opcode)
      OPC_OP: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_ctrl  = {funct7[5], funct3};
        if (funct7 == F7_BASE) begin
          illegal = 1'b0;
        end else if (funct7 == F7_ALT) begin
          illegal = !((funct3 == 3'b000) || (funct3 == 3'b101));
        end else if ((funct7 == F7_MULDIV) && ENABLE_M) begin
          is_m = 1'b1;
          ctrl = md_bundle(funct3);
        end else begin
          illegal = 1'b1;
        end
      end

      OPC_OP_IMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_src   = IMM_I;
        // Only the right shifts carry an arithmetic/logical selector in bit 30.
        ctrl.alu_ctrl  = {(funct3 == 3'b101) ? funct7[5] : 1'b0, funct3};
        if (funct3 == 3'b001) begin
          illegal = (funct7 != F7_BASE);
        end else if (funct3 == 3'b101) begin
          illegal = !((funct7 == F7_BASE) || (funct7 == F7_ALT));
        end
      end

      OPC_LOAD: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_src   = IMM_I;
        ctrl.dest_src  = 1'b1;
        ctrl.mem_ctrl  = funct3;
        illegal        = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end

      OPC_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_src   = IMM_S;
        ctrl.mem_ctrl  = funct3;
        illegal        = funct3[2] || (funct3 == 3'b011);
      end

      OPC_BRANCH: begin
        ctrl.branch   = 1'b1;
        ctrl.imm_src  = IMM_B;
        ctrl.alu_ctrl = {1'b0, funct3};
        illegal       = (funct3 == 3'b010) || (funct3 == 3'b011);
      end

      OPC_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_src   = IMM_U;
        ctrl.op_a_sel  = OPA_ZERO;
      end

      OPC_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_src   = IMM_U;
        ctrl.op_a_sel  = OPA_PC;
      end

      OPC_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_src   = IMM_J;
        ctrl.op_a_sel  = OPA_PC;
      end

      OPC_JALR: begin
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.jalr      = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_src   = IMM_I;
        ctrl.op_a_sel  = OPA_PC;
        illegal        = (funct3 != 3'b000);
      end

      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Registered RV32IM decode/control stage: ID/EX control register with stall/flush,
// illegal-instruction flag, and a counter FSM that sequences multi-cycle mul/div.
module decode_ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int MUL_LAT  = 1,
  parameter int DIV_LAT  = 32,
  parameter bit ENABLE_M = 1'b1,
  parameter int CNT_W    = $clog2((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT) + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_i,
  input  logic        instr_valid_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        valid_o,
  output logic        reg_write_o,
  output logic [3:0]  alu_ctrl_o,
  output logic        alu_src_o,
  output logic [2:0]  imm_src_o,
  output logic [1:0]  op_a_sel_o,
  output logic        dest_src_o,
  output logic [2:0]  mem_ctrl_o,
  output logic        mem_write_o,
  output logic        branch_o,
  output logic        jump_o,
  output logic        jalr_o,
  output logic        md_sel_o,
  output logic [2:0]  md_op_o,
  output logic        md_start_o,
  output logic        md_kill_o,
  output logic        stall_o,
  output logic        illegal_o
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  ctrl_bundle_t dec_ctrl;
  logic         dec_is_m;
  logic         dec_illegal;

  decode_comb #(
    .ENABLE_M(ENABLE_M)
  ) u_decode (
    .opcode (instr_i[6:0]),
    .funct3 (instr_i[14:12]),
    .funct7 (instr_i[31:25]),
    .ctrl   (dec_ctrl),
    .is_m   (dec_is_m),
    .illegal(dec_illegal)
  );

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       md_op_q, md_op_d;
  ctrl_bundle_t     out_q, out_d;
  logic             valid_q, valid_d;
  logic             illegal_q, illegal_d;
  logic             start_q, start_d;
  logic             kill_q, kill_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    md_op_d   = md_op_q;
    out_d     = out_q;
    valid_d   = valid_q;
    illegal_d = illegal_q;
    start_d   = 1'b0;
    kill_d    = 1'b0;

    unique case (state_q)
      MD_IDLE: begin
        if (flush_i) begin
          out_d     = CTRL_BUBBLE;
          valid_d   = 1'b0;
          illegal_d = 1'b0;
        end else if (!stall_i) begin
          if (instr_valid_i && dec_is_m) begin
            // Accept the M op; its result bundle is issued when the counter expires.
            state_d   = MD_BUSY;
            cnt_d     = instr_i[14] ? DIV_CNT : MUL_CNT;
            md_op_d   = instr_i[14:12];
            start_d   = 1'b1;
            out_d     = CTRL_BUBBLE;
            valid_d   = 1'b0;
            illegal_d = 1'b0;
          end else begin
            valid_d   = instr_valid_i && !dec_illegal;
            out_d     = valid_d ? dec_ctrl : CTRL_BUBBLE;
            illegal_d = instr_valid_i && dec_illegal;
          end
        end
      end

      MD_BUSY: begin
        out_d     = CTRL_BUBBLE;
        valid_d   = 1'b0;
        illegal_d = 1'b0;
        if (flush_i) begin
          state_d = MD_IDLE;
          kill_d  = 1'b1;
        end else if (cnt_q == '0) begin
          if (!stall_i) begin
            state_d = MD_IDLE;
            out_d   = md_bundle(md_op_q);
            valid_d = 1'b1;
          end else begin
            state_d = MD_WAIT;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      MD_WAIT: begin
        if (flush_i) begin
          state_d   = MD_IDLE;
          kill_d    = 1'b1;
          out_d     = CTRL_BUBBLE;
          valid_d   = 1'b0;
          illegal_d = 1'b0;
        end else if (!stall_i) begin
          state_d   = MD_IDLE;
          out_d     = md_bundle(md_op_q);
          valid_d   = 1'b1;
          illegal_d = 1'b0;
        end
      end

      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      md_op_q   <= '0;
      out_q     <= CTRL_BUBBLE;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      start_q   <= 1'b0;
      kill_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking updates keep every flop sampling pre-edge values regardless of statement order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      md_op_q   <= md_op_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      start_q   <= start_d;
      kill_q    <= kill_d;
    end
  end

  assign valid_o     = valid_q;
  assign reg_write_o = out_q.reg_write;
  assign alu_ctrl_o  = out_q.alu_ctrl;
  assign alu_src_o   = out_q.alu_src;
  assign imm_src_o   = out_q.imm_src;
  assign op_a_sel_o  = out_q.op_a_sel;
  assign dest_src_o  = out_q.dest_src;
  assign mem_ctrl_o  = out_q.mem_ctrl;
  assign mem_write_o = out_q.mem_write;
  assign branch_o    = out_q.branch;
  assign jump_o      = out_q.jump;
  assign jalr_o      = out_q.jalr;
  assign md_sel_o    = out_q.md_sel;
  assign md_op_o     = out_q.md_op;
  assign md_start_o  = start_q;
  assign md_kill_o   = kill_q;
  assign stall_o     = (state_q != MD_IDLE);
  assign illegal_o   = illegal_q;

endmodule
